fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage feeding the decoder. Holds the PC and fetches 16-bit words
//   over a req/ready memory handshake. Presents each word with a one-cycle-per-word
//   valid strobe that drives the decoder enable. Takes jump redirects from execute.
// PARAMETERS
//   PC_WIDTH     8    PC / memory word-address width (matches 8-bit jump immediate)
//   RESET_PC     0    PC value loaded on reset
//   WDOG_CYCLES  16   max REQ cycles without I_mem_ready before fault (FETCH_WDOG_EN only)
// PORTS
//   I_clk          in   1         clock, all logic on posedge
//   I_reset        in   1         synchronous, active-high reset
//   I_enable       in   1         run enable; low = no new memory requests
//   I_stall        in   1         downstream cannot accept O_instruction this cycle
//   I_jump         in   1         redirect request (one-cycle pulse)
//   I_jump_target  in   PC_WIDTH  redirect address
//   I_mem_ready    in   1         memory returns I_mem_data this cycle
//   I_mem_data     in   16        instruction word
//   O_mem_req      out  1         fetch request
//   O_mem_addr     out  PC_WIDTH  fetch address (= PC)
//   O_instruction  out  16        fetched word to decoder
//   O_valid        out  1         O_instruction valid (decoder enable)
//   O_pc           out  PC_WIDTH  address of O_instruction
//   O_fault        out  1         fetch timeout, sticky (constant 0 without FETCH_WDOG_EN)
// BEHAVIOUR
//   - Reset: state IDLE, PC=RESET_PC, O_mem_req=0, O_valid=0, O_instruction=0,
//     O_pc=RESET_PC, O_fault=0, watchdog counter=0. Reset mid-fetch drops the request.
//   - Outputs are registered. O_mem_addr always equals the PC register.
//   - States:
//     - IDLE: O_mem_req=0. Goes to REQ when I_enable=1.
//     - REQ: O_mem_req=1, address held stable.
//       - I_mem_ready=1: capture I_mem_data into O_instruction and PC into O_pc,
//         set O_valid=1, go to VALID.
//       - I_enable=0 (and I_mem_ready=0): drop O_mem_req, go to IDLE.
//     - VALID: O_valid=1, outputs held.
//       - I_stall=0: word is consumed this cycle; PC<=PC+1, O_valid<=0, go to REQ
//         (or to IDLE if I_enable=0).
//       - I_stall=1: hold everything.
//   - Throughput: zero-wait memory gives 1 word per 2 cycles. The request is issued in
//     the cycle after reset release when I_enable=1.
//   - Memory may see O_mem_req drop without ready; that is legal and the memory discards it.
//   - Jump (highest priority after reset), in any state:
//     - PC<=I_jump_target, O_valid<=0, go to REQ (or IDLE if I_enable=0).
//     - Data returned in the same cycle (I_mem_ready=1) is discarded.
//     - A word held in VALID is discarded, whether or not I_stall is high.
//   - PC increment wraps modulo 2^PC_WIDTH (all-ones + 1 = 0). A jump target is taken verbatim.
//   - I_stall is ignored outside VALID. I_enable low never clears O_valid.
// CONFIGURATION
//   FETCH_WDOG_EN defined:
//     - A counter increments each REQ cycle with I_mem_ready=0 and clears on leaving REQ.
//     - When the count reaches WDOG_CYCLES: O_fault<=1, O_mem_req<=0, go to FAULT.
//     - FAULT: O_valid=0, jumps ignored; exit only via I_reset.
//   FETCH_WDOG_EN undefined:
//     - No counter and no FAULT state; REQ waits indefinitely.
//     - O_fault tied to 0.
// TESTING
//   1. Reset, I_enable=1, zero-wait memory where word=addr^16'hA500
//      -> O_valid pulses every 2 cycles, O_pc=0,1,2 with O_instruction=A500,A501,A502.
//   2. I_stall=1 for 5 cycles while O_valid=1 with O_pc=3
//      -> O_instruction, O_pc and O_valid held; no O_mem_req; after release, next O_pc=4.
//   3. PC=8'hFF, word consumed -> next O_mem_addr=8'h00 (wrap).
//   4. I_jump=1, I_jump_target=8'h40 in the same cycle as I_mem_ready=1 at addr 5
//      -> that word is never presented; next O_mem_addr=8'h40, next O_pc=8'h40.
//   5. I_reset asserted during REQ with memory stalled
//      -> next cycle O_mem_req=0, O_valid=0, O_pc=RESET_PC.
//   6. FETCH_WDOG_EN, WDOG_CYCLES=4, I_mem_ready held 0
//      -> O_fault=1 and O_mem_req=0 after 4 REQ cycles; I_jump ignored; I_reset clears.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/ready memory handshake, one-word valid strobe.
// Optional fetch watchdog with sticky fault is enabled by defining FETCH_WDOG_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  WDOG_CYCLES = 16
) (
    input  logic                I_clk,
    input  logic                I_reset,
    input  logic                I_enable,
    input  logic                I_stall,
    input  logic                I_jump,
    input  logic [PC_WIDTH-1:0] I_jump_target,
    input  logic                I_mem_ready,
    input  logic [15:0]         I_mem_data,
    output logic                O_mem_req,
    output logic [PC_WIDTH-1:0] O_mem_addr,
    output logic [15:0]         O_instruction,
    output logic                O_valid,
    output logic [PC_WIDTH-1:0] O_pc,
    output logic                O_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID
`ifdef FETCH_WDOG_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_req;
    logic                r_valid;
    logic [15:0]         r_instr;
    logic [PC_WIDTH-1:0] r_opc;
    logic                w_jump;

`ifdef FETCH_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);

    logic [WDW-1:0] r_wdog;
    logic           r_fault;

    // A faulted fetch unit only leaves FAULT through reset.
    assign w_jump  = I_jump && (r_state != S_FAULT);
    assign O_fault = r_fault;
`else
    logic w_unused;

    assign w_unused = ^WDOG_CYCLES;
    assign w_jump   = I_jump;
    assign O_fault  = 1'b0;
`endif

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_opc   <= RESET_PC;
`ifdef FETCH_WDOG_EN
            r_wdog  <= '0;
            r_fault <= 1'b0;
`endif
        end else if (w_jump) begin
            r_pc    <= I_jump_target;
            r_valid <= 1'b0;
            r_req   <= I_enable;
            r_state <= I_enable ? S_REQ : S_IDLE;
`ifdef FETCH_WDOG_EN
            r_wdog  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (I_enable) begin
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (I_mem_ready) begin
                        r_instr <= I_mem_data;
                        r_opc   <= r_pc;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_VALID;
`ifdef FETCH_WDOG_EN
                        r_wdog  <= '0;
`endif
                    end else if (!I_enable) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
`ifdef FETCH_WDOG_EN
                        r_wdog  <= '0;
`endif
                    end
`ifdef FETCH_WDOG_EN
                    else if (r_wdog == WDOG_LAST) begin
                        r_fault <= 1'b1;
                        r_req   <= 1'b0;
                        r_wdog  <= '0;
                        r_state <= S_FAULT;
                    end else begin
                        r_wdog  <= r_wdog + 1'b1;
                    end
`endif
                end
                S_VALID: begin
                    if (!I_stall) begin
                        r_pc    <= r_pc + 1'b1;
                        r_valid <= 1'b0;
                        r_req   <= I_enable;
                        r_state <= I_enable ? S_REQ : S_IDLE;
                    end
                end
`ifdef FETCH_WDOG_EN
                S_FAULT: begin
                    r_valid <= 1'b0;
                    r_req   <= 1'b0;
                end
`endif
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign O_mem_req     = r_req;
    assign O_mem_addr    = r_pc;
    assign O_instruction = r_instr;
    assign O_valid       = r_valid;
    assign O_pc          = r_opc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam int PW = 8;
    localparam int WD = 4;
`ifdef FETCH_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          I_clk = 1'b0;
    logic          I_reset;
    logic          I_enable;
    logic          I_stall;
    logic          I_jump;
    logic [PW-1:0] I_jump_target;
    logic          I_mem_ready;
    logic [15:0]   I_mem_data;
    logic          O_mem_req;
    logic [PW-1:0] O_mem_addr;
    logic [15:0]   O_instruction;
    logic          O_valid;
    logic [PW-1:0] O_pc;
    logic          O_fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the observable fetch-unit outputs plus a miss count
    logic [PW-1:0] m_pc;
    logic          m_req;
    logic          m_valid;
    logic [15:0]   m_instr;
    logic [PW-1:0] m_opc;
    logic          m_fault;
    int            m_miss;

    fetch_unit #(
        .PC_WIDTH   (PW),
        .RESET_PC   ('0),
        .WDOG_CYCLES(WD)
    ) dut (
        .I_clk        (I_clk),
        .I_reset      (I_reset),
        .I_enable     (I_enable),
        .I_stall      (I_stall),
        .I_jump       (I_jump),
        .I_jump_target(I_jump_target),
        .I_mem_ready  (I_mem_ready),
        .I_mem_data   (I_mem_data),
        .O_mem_req    (O_mem_req),
        .O_mem_addr   (O_mem_addr),
        .O_instruction(O_instruction),
        .O_valid      (O_valid),
        .O_pc         (O_pc),
        .O_fault      (O_fault)
    );

    always #5 I_clk = ~I_clk;

    function automatic logic [15:0] mem_word(input logic [PW-1:0] a);
        return 16'hA500 ^ {8'h00, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_req   = 1'b0;
        m_valid = 1'b0;
        m_instr = '0;
        m_opc   = '0;
        m_fault = 1'b0;
        m_miss  = 0;
    endtask

    // One clock: drive at negedge, advance model, compare at next negedge
    task automatic step(input logic rst, input logic en, input logic st,
                        input logic jp, input logic [PW-1:0] tgt,
                        input logic rdy);
        logic m_rd;
        I_reset       = rst;
        I_enable      = en;
        I_stall       = st;
        I_jump        = jp;
        I_jump_target = tgt;
        I_mem_ready   = O_mem_req & rdy;
        I_mem_data    = mem_word(O_mem_addr);
        m_rd          = m_req & rdy;
        if (rst) begin
            model_reset();
        end else if (m_fault) begin
            m_valid = 1'b0;
            m_req   = 1'b0;
        end else if (jp) begin
            m_pc    = tgt;
            m_valid = 1'b0;
            m_req   = en;
            m_miss  = 0;
        end else if (m_req) begin
            if (m_rd) begin
                m_instr = mem_word(m_pc);
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_req   = 1'b0;
                m_miss  = 0;
            end else if (!en) begin
                m_req  = 1'b0;
                m_miss = 0;
            end else begin
                m_miss++;
                if (WDOG_ON && m_miss == WD) begin
                    m_fault = 1'b1;
                    m_req   = 1'b0;
                    m_miss  = 0;
                end
            end
        end else if (m_valid) begin
            if (!st) begin
                m_pc    = m_pc + 1'b1;
                m_valid = 1'b0;
                m_req   = en;
            end
        end else begin
            m_req = en;
        end
        @(posedge I_clk);
        @(negedge I_clk);
        check("mem_req", 32'(O_mem_req), 32'(m_req));
        check("mem_addr", 32'(O_mem_addr), 32'(m_pc));
        check("valid", 32'(O_valid), 32'(m_valid));
        check("instr", 32'(O_instruction), 32'(m_instr));
        check("pc", 32'(O_pc), 32'(m_opc));
        check("fault", 32'(O_fault), 32'(m_fault));
    endtask

    initial begin
        I_reset       = 1'b1;
        I_enable      = 1'b0;
        I_stall       = 1'b0;
        I_jump        = 1'b0;
        I_jump_target = '0;
        I_mem_ready   = 1'b0;
        I_mem_data    = '0;
        model_reset();
        @(negedge I_clk);

        step(1, 1, 0, 0, 8'h00, 1);
        step(1, 1, 0, 0, 8'h00, 1);
        check("rst_req", 32'(O_mem_req), 32'd0);
        check("rst_pc", 32'(O_pc), 32'd0);

        // Zero-wait memory streams words 0..3
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'h00, 1);
        check("t1_valid", 32'(O_valid), 32'd1);
        check("t1_pc", 32'(O_pc), 32'd3);
        check("t1_instr", 32'(O_instruction), 32'hA503);

        // Stall holds the word at pc 3
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 8'h00, 1);
            check("t2_hold_pc", 32'(O_pc), 32'd3);
            check("t2_hold_req", 32'(O_mem_req), 32'd0);
        end
        step(0, 1, 0, 0, 8'h00, 1);
        step(0, 1, 0, 0, 8'h00, 1);
        check("t2_next_pc", 32'(O_pc), 32'd4);

        // Wrap from 0xFF
        step(0, 1, 0, 1, 8'hFF, 1);
        step(0, 1, 0, 0, 8'h00, 1);
        check("t3_pc_ff", 32'(O_pc), 32'hFF);
        step(0, 1, 0, 0, 8'h00, 1);
        check("t3_wrap", 32'(O_mem_addr), 32'h00);

        // Jump collides with ready at address 5
        step(0, 1, 0, 1, 8'h05, 0);
        step(0, 1, 0, 1, 8'h40, 1);
        check("t4_addr", 32'(O_mem_addr), 32'h40);
        check("t4_novalid", 32'(O_valid), 32'd0);
        step(0, 1, 0, 0, 8'h00, 1);
        check("t4_pc", 32'(O_pc), 32'h40);
        check("t4_instr", 32'(O_instruction), 32'hA540);

        // Reset while memory is stalled
        step(0, 1, 0, 0, 8'h00, 0);
        step(0, 1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 0, 8'h00, 0);
        check("t5_req", 32'(O_mem_req), 32'd0);
        check("t5_valid", 32'(O_valid), 32'd0);
        check("t5_pc", 32'(O_pc), 32'd0);

`ifdef FETCH_WDOG_EN
        step(0, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < WD; i++) step(0, 1, 0, 0, 8'h00, 0);
        check("t6_fault", 32'(O_fault), 32'd1);
        check("t6_req", 32'(O_mem_req), 32'd0);
        step(0, 1, 0, 1, 8'h22, 1);
        check("t6_jump_ign", 32'(O_mem_addr), 32'd0);
        step(1, 1, 0, 0, 8'h00, 0);
        check("t6_clear", 32'(O_fault), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(7) != 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(9) == 0),
                 PW'($urandom),
                 ($urandom_range(1) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
